// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video RAM between the scanout fetch
// port and the CPU bus. Video fetches always win the slot and return data a
// fixed two cycles later. CPU accesses use the slots video leaves idle and
// complete with a one-cycle ready pulse. A two-stage owner tag follows every
// slot so that returning RAM data reaches the port that asked for it.
module vram_arbiter #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          vreq,
    input  logic [AW-1:0] vaddr,
    output logic [DW-1:0] vdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] { C_IDLE, C_WR, C_RD1, C_RD2 } cpu_state_t;

    // Owner of a RAM slot while it travels through the read pipeline.
    typedef enum logic [1:0] { TAG_NONE, TAG_V, TAG_C } tag_t;

    cpu_state_t    r_state;
    cpu_state_t    w_state_next;
    tag_t          r_tag1;        // slot issued on the last edge
    tag_t          r_tag2;        // slot whose data is on mem_rdata now
    tag_t          w_tag_issue;
    logic          w_cpu_slot;
    logic          w_ready_next;
    logic          r_cpu_ready;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_vdata;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;

    // The CPU gets the slot only when video is quiet, no CPU access is in
    // flight, and the previous completion pulse is not showing: during that
    // cycle the CPU still holds the old request, which must not run twice.
    assign w_cpu_slot = !vreq && cpu_req && (r_state == C_IDLE) && !r_cpu_ready;

    // Next state, completion pulse and slot tag for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_tag_issue  = TAG_NONE;

        if (vreq) begin
            w_tag_issue = TAG_V;
        end else if (w_cpu_slot && !cpu_we) begin
            w_tag_issue = TAG_C;
        end

        case (r_state)
            C_IDLE: begin
                if (w_cpu_slot) begin
                    w_state_next = cpu_we ? C_WR : C_RD1;
                    // A write completes in the cycle right after its slot.
                    w_ready_next = cpu_we;
                end
            end
            C_WR:    w_state_next = C_IDLE;
            C_RD1:   w_state_next = C_RD2;
            C_RD2: begin
                w_state_next = C_IDLE;
                w_ready_next = 1'b1;
            end
            default: w_state_next = C_IDLE;
        endcase
    end

    // CPU FSM state and the registered completion pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset_n) begin
            r_state     <= C_IDLE;
            r_cpu_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_ready <= w_ready_next;
        end
    end

    // RAM slot issue: video first, then a CPU access, else an idle slot
    // that keeps the address and never writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else if (vreq) begin
            r_mem_addr  <= vaddr;
            r_mem_we    <= 1'b0;
        end else if (w_cpu_slot) begin
            r_mem_addr  <= cpu_addr;
            r_mem_we    <= cpu_we;
            r_mem_wdata <= cpu_wdata;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    // Tag pipeline and return-data routing by slot owner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1      <= TAG_NONE;
            r_tag2      <= TAG_NONE;
            r_vdata     <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_tag1 <= w_tag_issue;
            r_tag2 <= r_tag1;
            if (r_tag2 == TAG_V) begin
                r_vdata <= mem_rdata;
            end
            if (r_tag2 == TAG_C) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign vdata     = r_vdata;
    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a behavioural RAM plus a reference
// model (shadow memory, video return schedule, CPU slot-availability rule).
module tb_vram_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } vexp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic [DW-1:0] vdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            vreq_hist [0:65535];
    bit            preloaded = 1'b0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            last_ready = -10;
    logic [DW-1:0] last_vdata = '0;
    bit            video_done;
    vexp_t         vq[$];

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .vreq      (vreq),
        .vaddr     (vaddr),
        .vdata     (vdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #20 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hC3;
    endfunction

    // Synchronous RAM, one-cycle read latency, write-first.
    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(AW'(i));
            preloaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end

    // Edge counter and the vreq value seen at each edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        vreq_hist[(cyc + 1) & 16'hFFFF] <= vreq;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one CPU access; returns the tick cpu_ready was seen (-1 on
    // timeout) and the tick the slot rules predict.
    task automatic cpu_op(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int rtick,
                          output int etick, output logic [DW-1:0] rd);
        int start;
        int e;
        int n;
        start = cyc + 1;
        if (we) ref_mem[addr] = wd;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        rtick = -1;
        n = 0;
        while (rtick < 0 && n < 400) begin
            tick();
            n++;
            if (cpu_ready === 1'b1) rtick = cyc;
        end
        rd = cpu_rdata;
        cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
        // Earliest slot: not before the request, not in the previous ready
        // cycle; each edge with vreq pushes it one further.
        e = (start > last_ready + 2) ? start : last_ready + 2;
        while (e < 65535 && vreq_hist[e]) e++;
        etick = e + (we ? 0 : 2);
        if (rtick >= 0) last_ready = rtick;
    endtask

    task automatic drive_video(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            logic v;
            case (mode)
                0:       v = (i % 2 == 0);
                1:       v = 1'($urandom);
                default: v = 1'b1;
            endcase
            vaddr = AW'($urandom_range(0, 65535));
            vreq  = v;
            if (v) vq.push_back('{due: cyc + 3, val: ref_mem[vaddr]});
            tick();
        end
        vreq = 1'b0;
        video_done = 1'b1;
    endtask

    task automatic video_scoreboard();
        int guard = 0;
        while ((!video_done || vq.size() != 0) && guard < 5000) begin
            tick();
            guard++;
            n_checks++;
            if (vq.size() != 0 && vq[0].due == cyc) begin
                if (vdata !== vq[0].val)
                    $display("FAIL video_data: tick %0d vdata=%h expected %h", cyc, vdata, vq[0].val);
                else n_pass++;
                last_vdata = vq[0].val;
                void'(vq.pop_front());
            end else begin
                if (vdata !== last_vdata)
                    $display("FAIL video_hold: tick %0d vdata=%h expected %h", cyc, vdata, last_vdata);
                else n_pass++;
            end
        end
        n_checks++;
        if (guard >= 5000) $display("FAIL video_timeout: %0d returns outstanding, expected 0", vq.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vreq = 1'($urandom); vaddr = AW'($urandom);
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            tick();
            n_checks++;
            if ({vdata, cpu_ready, cpu_rdata, mem_addr, mem_we, mem_wdata} !== '0)
                $display("FAIL reset_outputs: vdata=%h rdy=%b rdata=%h addr=%h we=%b wdata=%h expected all 0",
                         vdata, cpu_ready, cpu_rdata, mem_addr, mem_we, mem_wdata);
            else n_pass++;
        end
        vreq = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b1;
        last_ready = -10;
        last_vdata = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({cpu_ready, mem_we} !== 2'b00)
                $display("FAIL reset_release: rdy=%b we=%b expected 0 0", cpu_ready, mem_we);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h0F123; cpu_wdata = 8'hA5;
        ref_mem[17'h0F123] = 8'hA5;
        tick();
        n_checks++;
        if (cpu_ready !== 1'b1) $display("FAIL wr_ready: rdy=%b expected 1", cpu_ready);
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_we, mem_wdata} !== {17'h0F123, 1'b1, 8'hA5})
            $display("FAIL wr_bus: addr=%h we=%b wdata=%h expected 0f123 1 a5", mem_addr, mem_we, mem_wdata);
        else n_pass++;
        cpu_req = 1'b0; last_ready = cyc;
        tick();
        n_checks++;
        if ({cpu_ready, mem_we, mem_addr} !== {1'b0, 1'b0, 17'h0F123})
            $display("FAIL wr_after: rdy=%b we=%b addr=%h expected 0 0 0f123", cpu_ready, mem_we, mem_addr);
        else n_pass++;
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({cpu_ready, mem_we} !== 2'b00)
                $display("FAIL rd_wait: tick %0d rdy=%b we=%b expected 0 0", i, cpu_ready, mem_we);
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({cpu_ready, cpu_rdata} !== {1'b1, 8'hA5})
            $display("FAIL rd_done: rdy=%b rdata=%h expected 1 a5", cpu_ready, cpu_rdata);
        else n_pass++;
        cpu_req = 1'b0; last_ready = cyc;
        tick();
        n_checks++;
        if ({cpu_ready, cpu_rdata} !== {1'b0, 8'hA5})
            $display("FAIL rd_hold: rdy=%b rdata=%h expected 0 a5", cpu_ready, cpu_rdata);
        else n_pass++;
    endtask

    task automatic test_interleave();
        int rt;
        int et;
        logic [DW-1:0] rd;
        cpu_op(1'b1, 17'h00010, 8'h3C, rt, et, rd);
        n_checks++;
        if (rt !== et) $display("FAIL il_setup1: ready tick %0d expected %0d", rt, et); else n_pass++;
        cpu_op(1'b1, 17'h0F000, 8'h41, rt, et, rd);
        n_checks++;
        if (rt !== et) $display("FAIL il_setup2: ready tick %0d expected %0d", rt, et); else n_pass++;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
        tick();
        vreq = 1'b1; vaddr = 17'h0F000;
        tick();
        vreq = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ready, cpu_rdata, vdata} !== {1'b1, 8'h3C, last_vdata})
            $display("FAIL il_cpu: rdy=%b rdata=%h vdata=%h expected 1 3c %h", cpu_ready, cpu_rdata, vdata, last_vdata);
        else n_pass++;
        cpu_req = 1'b0; last_ready = cyc;
        tick();
        n_checks++;
        if ({cpu_ready, cpu_rdata, vdata} !== {1'b0, 8'h3C, 8'h41})
            $display("FAIL il_video: rdy=%b rdata=%h vdata=%h expected 0 3c 41", cpu_ready, cpu_rdata, vdata);
        else n_pass++;
        last_vdata = 8'h41;
    endtask

    task automatic test_write_then_fetch();
        logic [DW-1:0] d;
        d = ref_mem[17'h0ABCD] ^ DW'($urandom_range(1, 255));
        ref_mem[17'h0ABCD] = d;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h0ABCD; cpu_wdata = d;
        tick();
        n_checks++;
        if (cpu_ready !== 1'b1) $display("FAIL wf_ready: rdy=%b expected 1", cpu_ready); else n_pass++;
        cpu_req = 1'b0; last_ready = cyc;
        vreq = 1'b1; vaddr = 17'h0ABCD;
        tick();
        vreq = 1'b0;
        tick();
        tick();
        n_checks++;
        if (vdata !== d) $display("FAIL wf_vdata: vdata=%h expected %h", vdata, d); else n_pass++;
        last_vdata = d;
    endtask

    task automatic test_video_priority();
        video_done = 1'b0;
        fork
            drive_video(0, 24);
            begin
                for (int k = 0; k < 4; k++) begin
                    int rt;
                    int et;
                    logic [DW-1:0] rd;
                    cpu_op(1'b1, AW'(17'h10100 + k), DW'($urandom), rt, et, rd);
                    n_checks++;
                    if (rt !== et) $display("FAIL vp_write%0d: ready tick %0d expected %0d", k, rt, et);
                    else n_pass++;
                end
            end
            video_scoreboard();
        join
        for (int k = 0; k < 4; k++) begin
            int rt;
            int et;
            logic [DW-1:0] rd;
            cpu_op(1'b0, AW'(17'h10100 + k), 8'h00, rt, et, rd);
            n_checks++;
            if ({rt, rd} !== {et, ref_mem[17'h10100 + k]})
                $display("FAIL vp_readback%0d: tick %0d data %h expected tick %0d data %h",
                         k, rt, rd, et, ref_mem[17'h10100 + k]);
            else n_pass++;
        end
    endtask

    task automatic test_starvation();
        int t0;
        int rt;
        int et;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        a = AW'(17'h10000 + $urandom_range(0, 255));
        t0 = cyc;
        video_done = 1'b0;
        fork
            drive_video(2, 100);
            cpu_op(1'b0, a, 8'h00, rt, et, rd);
            video_scoreboard();
        join
        n_checks++;
        if (rt !== et) $display("FAIL starve_model: ready tick %0d expected %0d", rt, et); else n_pass++;
        n_checks++;
        if (rt !== t0 + 103) $display("FAIL starve_release: ready tick %0d expected %0d", rt, t0 + 103);
        else n_pass++;
        n_checks++;
        if (rd !== ref_mem[a]) $display("FAIL starve_data: rdata=%h expected %h", rd, ref_mem[a]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int rt;
        int et;
        logic [DW-1:0] rd;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h1F00F;
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_ready, mem_we, mem_addr, vdata, cpu_rdata} !== '0)
            $display("FAIL rst_mid: rdy=%b we=%b addr=%h vdata=%h rdata=%h expected all 0",
                     cpu_ready, mem_we, mem_addr, vdata, cpu_rdata);
        else n_pass++;
        cpu_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        last_ready = -10;
        last_vdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (cpu_ready !== 1'b0) $display("FAIL rst_no_ready: rdy=%b expected 0", cpu_ready);
            else n_pass++;
        end
        cpu_op(1'b0, 17'h1F00F, 8'h00, rt, et, rd);
        n_checks++;
        if ({rt, rd} !== {et, ref_mem[17'h1F00F]})
            $display("FAIL rst_new_read: tick %0d data %h expected tick %0d data %h", rt, rd, et, ref_mem[17'h1F00F]);
        else n_pass++;
    endtask

    task automatic test_random();
        video_done = 1'b0;
        fork
            drive_video(1, 300);
            begin
                for (int k = 0; k < 25; k++) begin
                    int rt;
                    int et;
                    logic we;
                    logic [AW-1:0] a;
                    logic [DW-1:0] rd;
                    logic [DW-1:0] exp_rd;
                    we = 1'($urandom);
                    a = AW'(17'h10000 + $urandom_range(0, 15));
                    exp_rd = ref_mem[a];
                    cpu_op(we, a, DW'($urandom), rt, et, rd);
                    n_checks++;
                    if (rt !== et) $display("FAIL rnd_latency%0d: ready tick %0d expected %0d", k, rt, et);
                    else n_pass++;
                    if (!we) begin
                        n_checks++;
                        if (rd !== exp_rd) $display("FAIL rnd_rdata%0d: rdata=%h expected %h", k, rd, exp_rd);
                        else n_pass++;
                    end
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                end
            end
            video_scoreboard();
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        vreq = 1'b0; vaddr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
        test_reset();
        test_write_read();
        test_interleave();
        test_write_then_fetch();
        test_video_priority();
        test_starvation();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
